// File: rtl/fprn_cfg_loader.sv
// Serial configuration loader for the resistor network: shifts in a CRC-8
// protected switch pattern, checks it and commits it break-before-make.
module fprn_cfg_loader #(
  parameter int NBITS       = 32,
  parameter int BBM_CYCLES  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sclk_in,
  input  logic             sdata_in,
  input  logic             latch_in,
  output logic [NBITS-1:0] sw_en,
  output logic             busy,
  output logic             cfg_ok,
  output logic             cfg_err,
  output logic             sdo
);

  localparam int SW      = NBITS + 8;
  localparam int CNT_MAX = NBITS + 9;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int BW      = (BBM_CYCLES > 1) ? $clog2(BBM_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_BREAK,
    S_APPLY
  } state_t;

  state_t state, state_d;

  logic [SYNC_STAGES-1:0] sclk_sync, sdata_sync, latch_sync;
  logic                   sclk_prev, latch_prev;
  logic                   sclk_rise, latch_rise, sd;

  logic [SW-1:0]    shreg, shreg_d;
  logic [CW-1:0]    count, count_d;
  logic [7:0]       crc, crc_d;
  logic [NBITS-1:0] pending, pending_d;
  logic [BW-1:0]    bbm_cnt, bbm_cnt_d;
  logic [NBITS-1:0] sw_en_d;
  logic             cfg_ok_d, cfg_err_d, busy_d;
  logic             fb;

  // The pins are fully asynchronous; only the last synchroniser stage is used.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync  <= '0;
      sdata_sync <= '0;
      latch_sync <= '0;
      sclk_prev  <= 1'b0;
      latch_prev <= 1'b0;
    end else begin
      sclk_sync  <= {sclk_sync[SYNC_STAGES-2:0], sclk_in};
      sdata_sync <= {sdata_sync[SYNC_STAGES-2:0], sdata_in};
      latch_sync <= {latch_sync[SYNC_STAGES-2:0], latch_in};
      sclk_prev  <= sclk_sync[SYNC_STAGES-1];
      latch_prev <= latch_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_rise  = sclk_sync[SYNC_STAGES-1] & ~sclk_prev;
  assign latch_rise = latch_sync[SYNC_STAGES-1] & ~latch_prev;
  assign sd         = sdata_sync[SYNC_STAGES-1];
  assign sdo        = shreg[SW-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      shreg   <= '0;
      count   <= '0;
      crc     <= '0;
      pending <= '0;
      bbm_cnt <= '0;
      sw_en   <= '0;
      cfg_ok  <= 1'b0;
      cfg_err <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_d;
      shreg   <= shreg_d;
      count   <= count_d;
      crc     <= crc_d;
      pending <= pending_d;
      bbm_cnt <= bbm_cnt_d;
      sw_en   <= sw_en_d;
      cfg_ok  <= cfg_ok_d;
      cfg_err <= cfg_err_d;
      busy    <= busy_d;
    end
  end

  // A latch edge takes priority over a simultaneous sclk edge; that bit is lost.
  always_comb begin
    state_d   = state;
    shreg_d   = shreg;
    count_d   = count;
    crc_d     = crc;
    pending_d = pending;
    bbm_cnt_d = bbm_cnt;
    sw_en_d   = sw_en;
    cfg_ok_d  = 1'b0;
    cfg_err_d = cfg_err;
    fb        = 1'b0;

    case (state)
      S_IDLE: begin
        if (latch_rise) begin
          if (count != '0) begin
            state_d = S_CHECK;
          end
        end else if (sclk_rise) begin
          shreg_d = {shreg[SW-2:0], sd};
          if (count != CW'(CNT_MAX)) begin
            count_d = count + 1'b1;
          end
          fb    = crc[7] ^ sd;
          crc_d = {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
      end

      S_CHECK: begin
        if ((count == CW'(NBITS + 8)) && (crc == 8'h00)) begin
          state_d   = S_BREAK;
          pending_d = shreg[SW-1:8];
          bbm_cnt_d = '0;
        end else begin
          state_d   = S_IDLE;
          cfg_err_d = 1'b1;
          shreg_d   = '0;
          count_d   = '0;
          crc_d     = '0;
        end
      end

      // Every switch stays open for BBM_CYCLES cycles before the new pattern.
      S_BREAK: begin
        sw_en_d = '0;
        if (bbm_cnt == BW'(BBM_CYCLES - 1)) begin
          state_d = S_APPLY;
        end else begin
          bbm_cnt_d = bbm_cnt + 1'b1;
        end
      end

      S_APPLY: begin
        sw_en_d   = pending;
        cfg_ok_d  = 1'b1;
        cfg_err_d = 1'b0;
        state_d   = S_IDLE;
        shreg_d   = '0;
        count_d   = '0;
        crc_d     = '0;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

endmodule

// File: tb/tb_fprn_cfg_loader.sv
// Self-checking bench for fprn_cfg_loader (NBITS=8, BBM_CYCLES=4, SYNC_STAGES=2):
// table of serial loads plus hand-written timing, busy and reset sequences.
module tb_fprn_cfg_loader;

  localparam int NBITS = 8;
  localparam int BBM   = 4;
  localparam int SYNC  = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             sclk_in, sdata_in, latch_in;
  logic [NBITS-1:0] sw_en;
  logic             busy, cfg_ok, cfg_err, sdo;

  fprn_cfg_loader #(
    .NBITS(NBITS),
    .BBM_CYCLES(BBM),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sclk_in(sclk_in),
    .sdata_in(sdata_in),
    .latch_in(latch_in),
    .sw_en(sw_en),
    .busy(busy),
    .cfg_ok(cfg_ok),
    .cfg_err(cfg_err),
    .sdo(sdo)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [23:0] bits;
    int          nbits;
    bit          exp_ok;
    logic [7:0]  exp_sw;
    logic        exp_err;
  } vec_t;

  int         checks = 0;
  int         errors = 0;
  int         ok_pulses = 0;
  logic [7:0] exp_q[$];
  logic [7:0] prev_sw = '0;
  logic [7:0] sb_exp;
  logic       mon_en = 1'b0;

  function automatic logic [7:0] crc8(input logic [7:0] d);
    logic [7:0] c;
    logic       f;
    c = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      f = c[7] ^ d[i];
      c = {c[6:0], 1'b0} ^ (f ? 8'h07 : 8'h00);
    end
    return c;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic shiftBit(input logic b);
    sdata_in = b;
    cyc(2);
    sclk_in = 1'b1;
    cyc(4);
    sclk_in = 1'b0;
    cyc(3);
  endtask

  task automatic applyStimulus(input logic [23:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) shiftBit(bits[i]);
  endtask

  task automatic pulseLatch();
    latch_in = 1'b1;
    cyc(4);
    latch_in = 1'b0;
  endtask

  // Scoreboard side: each cfg_ok pops one expected pattern; any direct
  // nonzero-to-nonzero change of sw_en breaks the break-before-make rule.
  always @(negedge clk) begin
    if (mon_en) begin
      if (sw_en !== prev_sw) begin
        checks++;
        if (prev_sw != 8'h00 && sw_en != 8'h00) begin
          errors++;
          $display("[TB] FAIL bbm_direct_change: got 0x%0h after 0x%0h, expected 0x00 between", sw_en, prev_sw);
        end
      end
      if (cfg_ok === 1'b1) begin
        ok_pulses++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_cfg_ok: got cfg_ok=1 with sw_en=0x%0h, expected no pulse", sw_en);
        end else begin
          sb_exp = exp_q.pop_front();
          checkOutput("scoreboard_sw_en", 32'(sw_en), 32'(sb_exp));
        end
      end
    end
    prev_sw = sw_en;
  end

  vec_t       vecs[9];
  int         ok_before;
  logic [7:0] c3c;

  initial begin
    rst = 1'b1;
    sclk_in = 1'b0;
    sdata_in = 1'b0;
    latch_in = 1'b0;
    cyc(3);
    checkOutput("reset_sw_en", 32'(sw_en), 32'h0);
    checkOutput("reset_busy", 32'(busy), 32'h0);
    checkOutput("reset_cfg_ok", 32'(cfg_ok), 32'h0);
    checkOutput("reset_cfg_err", 32'(cfg_err), 32'h0);
    checkOutput("reset_sdo", 32'(sdo), 32'h0);
    rst = 1'b0;
    cyc(2);
    mon_en = 1'b1;

    c3c = crc8(8'h3C);
    vecs[0] = '{"load01",    24'h000107,                         16, 1'b1, 8'h01, 1'b0};
    vecs[1] = '{"loadFF",    24'h00FFF3,                         16, 1'b1, 8'hFF, 1'b0};
    vecs[2] = '{"badcrc",    24'h00FFF2,                         16, 1'b0, 8'hFF, 1'b1};
    vecs[3] = '{"loadA5",    {8'h00, 8'hA5, crc8(8'hA5)},        16, 1'b1, 8'hA5, 1'b0};
    vecs[4] = '{"zero_bits", 24'h000000,                          0, 1'b0, 8'hA5, 1'b0};
    vecs[5] = '{"load00",    24'h000000,                         16, 1'b1, 8'h00, 1'b0};
    vecs[6] = '{"short15",   {8'h00, 8'h3C, c3c},                15, 1'b0, 8'h00, 1'b1};
    vecs[7] = '{"long17",    {7'h00, 1'b1, 8'h3C, c3c},          17, 1'b0, 8'h00, 1'b1};
    vecs[8] = '{"load3C",    {8'h00, 8'h3C, c3c},                16, 1'b1, 8'h3C, 1'b0};

    for (int v = 0; v < 9; v++) begin
      ok_before = ok_pulses;
      applyStimulus(vecs[v].bits, vecs[v].nbits);
      checkOutput({vecs[v].name, "_sdo"}, 32'(sdo),
                  (vecs[v].nbits >= 16) ? 32'(vecs[v].bits[15]) : 32'h0);
      if (vecs[v].exp_ok) exp_q.push_back(vecs[v].exp_sw);
      pulseLatch();
      cyc(25);
      checkOutput({vecs[v].name, "_sw_en"}, 32'(sw_en), 32'(vecs[v].exp_sw));
      checkOutput({vecs[v].name, "_cfg_err"}, 32'(cfg_err), 32'(vecs[v].exp_err));
      checkOutput({vecs[v].name, "_busy"}, 32'(busy), 32'h0);
      checkOutput({vecs[v].name, "_ok_pulses"}, 32'(ok_pulses - ok_before), 32'(vecs[v].exp_ok));
    end

    // Cycle-exact commit timing from the latch pin edge.
    applyStimulus({8'h00, 8'h5A, crc8(8'h5A)}, 16);
    exp_q.push_back(8'h5A);
    latch_in = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      if (k == 4) latch_in = 1'b0;
      checkOutput($sformatf("timing_sw_en_k%0d", k), 32'(sw_en),
                  (k <= 4) ? 32'h3C : ((k <= 8) ? 32'h0 : 32'h5A));
      checkOutput($sformatf("timing_busy_k%0d", k), 32'(busy), (k >= 3 && k <= 8) ? 32'h1 : 32'h0);
      checkOutput($sformatf("timing_cfg_ok_k%0d", k), 32'(cfg_ok), (k == 9) ? 32'h1 : 32'h0);
    end
    cyc(5);

    // Latch and sclk rising together: the extra bit is dropped, load succeeds.
    applyStimulus({8'h00, 8'hC3, crc8(8'hC3)}, 16);
    exp_q.push_back(8'hC3);
    sdata_in = 1'b1;
    cyc(2);
    sclk_in = 1'b1;
    latch_in = 1'b1;
    cyc(4);
    sclk_in = 1'b0;
    latch_in = 1'b0;
    cyc(25);
    checkOutput("simul_sw_en", 32'(sw_en), 32'hC3);
    checkOutput("simul_cfg_err", 32'(cfg_err), 32'h0);

    // sclk edges while busy are discarded.
    applyStimulus({8'h00, 8'h81, crc8(8'h81)}, 16);
    exp_q.push_back(8'h81);
    latch_in = 1'b1;
    cyc(3);
    checkOutput("busy_during_commit", 32'(busy), 32'h1);
    latch_in = 1'b0;
    sdata_in = 1'b1;
    sclk_in = 1'b1;
    cyc(1);
    sclk_in = 1'b0;
    cyc(1);
    sclk_in = 1'b1;
    cyc(1);
    sclk_in = 1'b0;
    cyc(20);
    checkOutput("busy_sclk_sw_en", 32'(sw_en), 32'h81);
    checkOutput("busy_sclk_sdo", 32'(sdo), 32'h0);
    applyStimulus({8'h00, 8'h42, crc8(8'h42)}, 16);
    exp_q.push_back(8'h42);
    pulseLatch();
    cyc(25);
    checkOutput("after_busy_sw_en", 32'(sw_en), 32'h42);
    checkOutput("after_busy_cfg_err", 32'(cfg_err), 32'h0);

    // Reset in the middle of BREAK discards both old and pending configs.
    applyStimulus(24'h00FFF2, 16);
    pulseLatch();
    cyc(25);
    checkOutput("pre_reset_cfg_err", 32'(cfg_err), 32'h1);
    applyStimulus({8'h00, 8'h99, crc8(8'h99)}, 16);
    exp_q.push_back(8'h99);
    latch_in = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      if (k == 4) latch_in = 1'b0;
    end
    checkOutput("break_sw_en", 32'(sw_en), 32'h0);
    checkOutput("break_busy", 32'(busy), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_break_sw_en", 32'(sw_en), 32'h0);
    checkOutput("rst_break_busy", 32'(busy), 32'h0);
    checkOutput("rst_break_cfg_err", 32'(cfg_err), 32'h0);
    checkOutput("rst_break_cfg_ok", 32'(cfg_ok), 32'h0);
    exp_q.delete();
    rst = 1'b0;
    cyc(20);
    checkOutput("rst_discard_sw_en", 32'(sw_en), 32'h0);
    applyStimulus({8'h00, 8'h66, crc8(8'h66)}, 16);
    exp_q.push_back(8'h66);
    pulseLatch();
    cyc(25);
    checkOutput("reload_sw_en", 32'(sw_en), 32'h66);
    checkOutput("reload_cfg_err", 32'(cfg_err), 32'h0);

    checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
